// File: rtl/aes_mix_seq.sv
// Sequential MixColumns/InvMixColumns wrapper: feeds one column per cycle to a shared
// combinational aes_mix_columns unit. Optional pass-through via AES_MIX_SEQ_BYPASS_EN.
module aes_mix_seq #(
  parameter int NUM_COLS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
`ifdef AES_MIX_SEQ_BYPASS_EN
  input  logic                     bypass_i,
`endif
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [127:0]             state_i,
  input  logic                     fwd_ninv_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [127:0]             state_o,
  output logic [31:0]              mc_col_o,
  output logic                     mc_fwd_ninv_o,
  input  logic [31:0]              mc_col_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                       fsm;
  fsm_t                       fsm_next;
  logic                       accept;
  logic [1:0]                 cnt;
  logic [1:0]                 col_idx;
  logic                       fwd_p0;
  logic                       bypass_run;
  logic [NUM_COLS-1:0][31:0]  data_p0;

  // Column 0 lives in the top word, so the packed index runs opposite to the counter.
  assign col_idx       = ~cnt;
  assign state_o       = data_p0;
  assign mc_fwd_ninv_o = fwd_p0;

`ifdef AES_MIX_SEQ_BYPASS_EN
  logic bypass_p0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bypass_p0 <= 1'b0;
    end else if (accept) begin
      bypass_p0 <= bypass_i;
    end
  end

  assign bypass_run = bypass_p0;
`else
  assign bypass_run = 1'b0;
`endif

  always_comb begin
    fsm_next    = fsm;
    accept      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    mc_col_o    = '0;
    case (fsm)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        accept     = in_valid_i;
        if (in_valid_i) fsm_next = RUN;
      end
      RUN: begin
        if (!bypass_run) mc_col_o = data_p0[col_idx];
        if (cnt == 2'd3) fsm_next = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Stage p0: captured state, rewritten in place one column per RUN cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm     <= IDLE;
      cnt     <= 2'd0;
      fwd_p0  <= 1'b1;
      data_p0 <= '0;
    end else begin
      fsm <= fsm_next;
      if (accept) begin
        data_p0 <= state_i;
        fwd_p0  <= fwd_ninv_i;
        cnt     <= 2'd0;
      end else if (fsm == RUN) begin
        if (!bypass_run) data_p0[col_idx] <= mc_col_i;
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_mix_seq.sv
// Self-checking bench for aes_mix_seq; models the shared aes_mix_columns unit with GF(2^8) arithmetic.
module tb_aes_mix_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         bypass;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         fwd_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [31:0]  mc_col_o;
  logic         mc_fwd;
  logic [31:0]  mc_col_i;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_mix_seq #(.NUM_COLS(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef AES_MIX_SEQ_BYPASS_EN
    .bypass_i      (bypass),
`endif
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .state_i       (state_in),
    .fwd_ninv_i    (fwd_in),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .state_o       (state_out),
    .mc_col_o      (mc_col_o),
    .mc_fwd_ninv_o (mc_fwd),
    .mc_col_i      (mc_col_i),
    .busy_o        (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd);
    logic [7:0]  a[4];
    logic [7:0]  m[4];
    logic [7:0]  acc;
    logic [31:0] r = '0;
    if (fwd) m = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int row = 0; row < 4; row++) begin
      acc = 8'h00;
      for (int c = 0; c < 4; c++) acc = acc ^ gmul(m[(c - row + 4) % 4], a[c]);
      r[31-8*row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s, input logic fwd);
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32], fwd);
    return r;
  endfunction

  // Stand-in for the external combinational aes_mix_columns unit
  always_comb mc_col_i = mix_col(mc_col_o, mc_fwd);

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid; n = edges elapsed since the caller's last sample point.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_idle", {127'd0, busy}, 128'd0);
  endtask

  task automatic run_op(input logic [127:0] s, input logic fwd, input logic byp,
                        input logic do_drain, output logic [127:0] res);
    int n;
    int k;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    state_in = s;
    fwd_in   = fwd;
    bypass   = byp;
    tick();
    in_valid = 1'b0;
    fwd_in   = 1'($urandom);
    bypass   = 1'($urandom);
    state_in = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    k = 0;
    while (!out_valid && n < 20) begin
      if (k < 4) begin
        chk("run_col", {96'd0, mc_col_o}, byp ? 128'd0 : {96'd0, s[127-32*k -: 32]});
        chk("run_dir", {127'd0, mc_fwd}, {127'd0, fwd});
      end
      tick();
      n++;
      k++;
    end
    chk("latency", n, 4);
    chk("done_flags", {124'd0, out_valid, in_ready, busy, |mc_col_o}, {124'd0, 4'b1010});
    res = state_out;
    if (do_drain) drain();
  endtask

  typedef struct {
    logic [127:0] st;
    logic         fwd;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs[7];
  logic [127:0] res;
  logic [127:0] r2;
  logic [127:0] s;
  logic         f;
  int           n;

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[2] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
    vecs[3] = '{128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vecs[4] = '{128'h0, 1'b1, 128'h0};
    vecs[5] = '{128'h01010101_01010101_01010101_01010101, 1'b0, 128'h01010101_01010101_01010101_01010101};
    vecs[6] = '{128'hc6c6c6c6_01010101_f20a225c_db135345, 1'b1, 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc};

    rst = 1'b1; bypass = 1'b0; in_valid = 1'b0; state_in = '0; fwd_in = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_flags", {124'd0, in_ready, out_valid, busy, mc_fwd}, {124'd0, 4'b1001});
    chk("rst_state", state_out, 128'd0);
    chk("rst_mc_col", {96'd0, mc_col_o}, 128'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].st, vecs[i].fwd, 1'b0, 1'b1, res);
      chk($sformatf("vec%0d", i), res, vecs[i].exp);
    end

    for (int i = 0; i < 16; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      f = 1'($urandom);
      run_op(s, f, 1'b0, 1'b1, res);
      chk("rand", res, ref_state(s, f));
    end

    for (int i = 0; i < 6; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run_op(s, 1'b1, 1'b0, 1'b1, res);
      run_op(res, 1'b0, 1'b0, 1'b1, r2);
      chk("roundtrip", r2, s);
    end

    // Backpressure, then drain with a new state already waiting.
    run_op(vecs[0].st, 1'b1, 1'b0, 1'b0, res);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {state_out, out_valid, in_ready}, {vecs[0].exp, 2'b10});
    end
    s = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1; in_valid = 1'b1; state_in = s; fwd_in = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("bp_drain", {125'd0, busy, in_ready, out_valid}, {125'd0, 3'b010});
    tick();
    in_valid = 1'b0;
    chk("bp_accept", {126'd0, busy, in_ready}, {126'd0, 2'b10});
    wait_done(n);
    chk("bp_latency", n, 4);
    chk("bp_result", state_out, ref_state(s, 1'b0));
    drain();

    // Reset after two columns have been rewritten.
    s = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; state_in = s; fwd_in = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_flags", {124'd0, busy, in_ready, out_valid, mc_fwd}, {124'd0, 4'b0101});
    chk("midrun_rst_state", {state_out, mc_col_o}, 160'd0);
    run_op({4{32'h01010101}}, 1'b1, 1'b0, 1'b1, res);
    chk("after_rst", res, {4{32'h01010101}});

    // Reset while holding a result in DONE.
    run_op(vecs[2].st, 1'b1, 1'b0, 1'b0, res);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("done_rst", {state_out, busy, out_valid, in_ready}, {128'd0, 3'b001});

    // Direction and in_valid activity during RUN must be ignored.
    in_valid = 1'b1; state_in = vecs[0].st; fwd_in = 1'b1;
    tick();
    n = 0;
    while (!out_valid && n < 20) begin
      fwd_in   = ~fwd_in;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      chk("dir_ready_low", {127'd0, in_ready}, 128'd0);
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("dir_latency", n, 4);
    chk("dir_result", state_out, vecs[0].exp);
    chk("dir_latched", {127'd0, mc_fwd}, 128'd1);
    drain();
    tick();
    chk("no_second_accept", {126'd0, busy, in_ready}, {126'd0, 2'b01});

`ifdef AES_MIX_SEQ_BYPASS_EN
    run_op(vecs[0].st, 1'b1, 1'b1, 1'b1, res);
    chk("bypass", res, vecs[0].st);
    run_op(vecs[0].st, 1'b1, 1'b0, 1'b1, res);
    chk("after_bypass", res, vecs[0].exp);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_mix_seq.md
AES_MIX_SEQ -- requirements
Module: aes_mix_seq

Interface
Parameters
REQ-001 The block SHALL expose parameter NUM_COLS, default 4, meaning the number of 32-bit columns per state; only the value 4 is supported.

Ports
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid_i, input, 1 bit: the input state is valid.
REQ-005 The block SHALL have port in_ready_o, output, 1 bit: the block can accept a state.
REQ-006 The block SHALL have port state_i, input, 128 bits: input state; column 0 = [127:96] and column 3 = [31:0].
REQ-007 The block SHALL have port fwd_ninv_i, input, 1 bit: 1 selects MixColumns, 0 selects InvMixColumns; sampled on accept.
REQ-008 The block SHALL have port out_valid_o, output, 1 bit: the result state is valid.
REQ-009 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port state_o, output, 128 bits: result state, same column order as state_i.
REQ-011 The block SHALL have port mc_col_o, output, 32 bits: column driven to the shared aes_mix_columns col_i.
REQ-012 The block SHALL have port mc_fwd_ninv_o, output, 1 bit: driven to aes_mix_columns fwd_ninv_i.
REQ-013 The block SHALL have port mc_col_i, input, 32 bits: aes_mix_columns col_o; combinational in the same cycle.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 in_ready_o SHALL be 1 only in IDLE.
REQ-017 Accept is in_valid_i & in_ready_o at a clock edge; on accept the block SHALL register state_i and fwd_ninv_i, clear the 2-bit column counter, and enter RUN.
REQ-018 In RUN, mc_col_o SHALL equal the registered column at the counter index, and mc_fwd_ninv_o SHALL equal the latched direction.
REQ-019 At each RUN edge, mc_col_i SHALL overwrite that column in place and the counter SHALL increment.
REQ-020 When the counter is 3, the block SHALL move to DONE instead of wrapping.
REQ-021 out_valid_o SHALL be high exactly in DONE, rising 4 edges after the accept edge.
REQ-022 state_o SHALL hold the register contents and remain stable while out_valid_o & !out_ready_i.
REQ-023 In DONE with out_ready_i = 1, the block SHALL return to IDLE; the next accept is possible 1 cycle later (minimum 6-cycle period per state).
REQ-024 In IDLE and DONE, mc_col_o SHALL be 32'h0 and mc_fwd_ninv_o SHALL hold its last latched value.
REQ-025 in_valid_i and fwd_ninv_i changes while busy SHALL be ignored; fwd_ninv_i is never re-sampled mid-operation.
REQ-026 out_ready_i SHALL be ignored outside DONE.

Reset
REQ-027 On rst_i = 1 at an edge, the block SHALL enter IDLE from any state, including mid-RUN or in DONE, and discard the in-flight state.
REQ-028 After reset, the outputs SHALL be: in_ready_o = 1, out_valid_o = 0, busy_o = 0, state_o = 128'h0, mc_col_o = 32'h0, mc_fwd_ninv_o = 1, column counter = 0.
REQ-029 Reset SHALL take priority over a simultaneous accept or drain.

Configuration
REQ-030 Macro AES_MIX_SEQ_BYPASS_EN, when defined, SHALL add input bypass_i (1 bit), sampled on accept.
REQ-031 With AES_MIX_SEQ_BYPASS_EN defined and bypass_i = 1, the block SHALL pass the state through unchanged (AES final round) with identical handshake timing, using the RUN cycles, and SHALL hold mc_col_o at 32'h0.
REQ-032 Without AES_MIX_SEQ_BYPASS_EN, bypass_i SHALL not exist and every accepted state SHALL be transformed.

Verification
REQ-033 Bench SHALL cover forward operation: state_i = db135345_f20a225c_01010101_c6c6c6c6 with fwd = 1 -> state_o = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid_o 4 edges after accept.
REQ-034 Bench SHALL cover inverse operation: state_i = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 with fwd = 0 -> state_o = db135345_f20a225c_01010101_c6c6c6c6; and a forward-then-inverse round trip on random states returns the original state.
REQ-035 Bench SHALL cover backpressure: out_ready_i = 0 for 10 cycles in DONE -> out_valid_o stays 1, state_o is stable, in_ready_o = 0; a drain followed by a back-to-back input is accepted exactly 1 cycle after the drain.
REQ-036 Bench SHALL cover reset mid-RUN (after 2 columns): next cycle busy_o = 0 and in_ready_o = 1; a fresh 01010101 x4 input completes correctly with no stale columns.
REQ-037 Bench SHALL cover direction stability: toggling fwd_ninv_i and pulsing in_valid_i during RUN -> result matches the latched direction and no second accept occurs.
REQ-038 With AES_MIX_SEQ_BYPASS_EN defined, bench SHALL drive bypass_i = 1 with db135345_f20a225c_01010101_c6c6c6c6 -> identical state_o after 4 edges, and mc_col_o = 0 throughout.
